// File: rtl/stripe_pkg.sv
// Shared types and arithmetic helpers for the stripe MAC array.
// Helpers work in a wide MATH_W domain so lanes of any width can use them.
package stripe_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam int MATH_W = 64;

  typedef struct packed {
    logic [1:0] op;
    logic       accum;
  } job_cfg_t;

  // Round half up, then arithmetic shift right by frac.
  function automatic logic signed [MATH_W-1:0] round_shr(
    input logic signed [MATH_W-1:0] p,
    input int unsigned              frac
  );
    logic signed [MATH_W-1:0] half;
    half = (frac == 0) ? 64'sd0 : (64'sd1 <<< (frac - 1));
    return (p + half) >>> frac;
  endfunction

  // Clamp to the signed range of a w-bit value.
  function automatic logic signed [MATH_W-1:0] sat_clamp(
    input logic signed [MATH_W-1:0] v,
    input int unsigned              w
  );
    logic signed [MATH_W-1:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/stripe_lane.sv
// One MAC lane: operand capture, op mux, mul rounding, accumulator, output conversion.
// STRIPE_SAT_EN selects saturating output; otherwise the result wraps.
module stripe_lane
  import stripe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 14,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cap_a,
  input  logic              cap_b,
  input  logic              step,
  input  logic [1:0]        op,
  input  logic              accum,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] res
);

  logic signed [DATA_W-1:0]   a_q, b_q;
  logic signed [ACC_W-1:0]    acc_q, a_ext, b_ext, f, acc_nxt;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [MATH_W-1:0]   prod_w, rnd_w;
  logic [DATA_W-1:0]          res_nxt;

  assign a_ext  = {{(ACC_W-DATA_W){a_q[DATA_W-1]}}, a_q};
  assign b_ext  = {{(ACC_W-DATA_W){b_q[DATA_W-1]}}, b_q};
  assign prod   = a_q * b_q;
  assign prod_w = {{(MATH_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign rnd_w  = round_shr(prod_w, FRAC_W);

  always_comb begin
    f = a_ext + b_ext;
    if (op[1])      f = rnd_w[ACC_W-1:0];
    else if (op[0]) f = a_ext - b_ext;
    acc_nxt = (accum ? acc_q : '0) + f;
  end

`ifdef STRIPE_SAT_EN
  logic signed [MATH_W-1:0] sat_w;
  assign sat_w   = sat_clamp({{(MATH_W-ACC_W){acc_nxt[ACC_W-1]}}, acc_nxt}, DATA_W);
  assign res_nxt = sat_w[DATA_W-1:0];
  logic unused_sat;
  assign unused_sat = ^sat_w[MATH_W-1:DATA_W];
`else
  assign res_nxt = acc_nxt[DATA_W-1:0];
`endif

  // The rounded product never exceeds ACC_W bits; upper bits are sign copies.
  logic unused_rnd;
  assign unused_rnd = ^rnd_w[MATH_W-1:ACC_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      res   <= '0;
    end else begin
      if (clr) begin
        acc_q <= '0;
        res   <= '0;
      end else if (step) begin
        acc_q <= acc_nxt;
        res   <= res_nxt;
      end
      if (cap_a) a_q <= d_in;
      if (cap_b) b_q <= d_in;
    end
  end

endmodule

// File: rtl/stripe_mac_array.sv
// NUM_PE-lane tagged MAC array: FSM, tag/stride and iteration tracking; lanes do the math.
// Output conversion is saturating when STRIPE_SAT_EN is defined, wrapping otherwise.
module stripe_mac_array
  import stripe_pkg::*;
#(
  parameter int NUM_PE = 8,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 14,
  parameter int ACC_W  = 32,
  parameter int TAG_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [1:0]               cfg_op,
  input  logic                     cfg_accum,
  input  logic [TAG_W-1:0]         cfg_tag_a,
  input  logic [TAG_W-1:0]         cfg_tag_b,
  input  logic [TAG_W-1:0]         cfg_stride_a,
  input  logic [TAG_W-1:0]         cfg_stride_b,
  input  logic [TAG_W-1:0]         cfg_iter_lim,
  input  logic                     in_valid,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [NUM_PE*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_PE*DATA_W-1:0] out_data,
  output logic                     busy
);

  state_t             state, state_nxt;
  job_cfg_t           job_q;
  logic [TAG_W-1:0]   tag_a, tag_b, stride_a, stride_b, iter_lim, iter, iter_inc;
  logic               a_ok, b_ok, cap_a, cap_b, cfg_fire, step;

  logic [NUM_PE-1:0][DATA_W-1:0] lane_in, lane_res;

  assign lane_in  = in_data;
  assign out_data = lane_res;

  assign cfg_fire = (state == S_IDLE) && cfg_valid;
  assign step     = (state == S_COMPUTE);
  assign iter_inc = iter + TAG_W'(1);
  // First capture wins: a lane operand is latched only while its flag is clear.
  assign cap_a    = (state == S_COLLECT) && in_valid && (in_tag == tag_a) && !a_ok;
  assign cap_b    = (state == S_COLLECT) && in_valid && (in_tag == tag_b) && !b_ok;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cfg_valid) state_nxt = (cfg_iter_lim == '0) ? S_DONE : S_COLLECT;
      S_COLLECT: if ((a_ok || cap_a) && (b_ok || cap_b)) state_nxt = S_COMPUTE;
      S_COMPUTE: state_nxt = (iter_inc == iter_lim) ? S_DONE : S_COLLECT;
      S_DONE:    if (out_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    out_valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      job_q    <= '0;
      tag_a    <= '0;
      tag_b    <= '0;
      stride_a <= '0;
      stride_b <= '0;
      iter_lim <= '0;
      iter     <= '0;
      a_ok     <= 1'b0;
      b_ok     <= 1'b0;
    end else if (cfg_fire) begin
      job_q    <= '{op: cfg_op, accum: cfg_accum};
      tag_a    <= cfg_tag_a;
      tag_b    <= cfg_tag_b;
      stride_a <= cfg_stride_a;
      stride_b <= cfg_stride_b;
      iter_lim <= cfg_iter_lim;
      iter     <= '0;
      a_ok     <= 1'b0;
      b_ok     <= 1'b0;
    end else if (step) begin
      tag_a <= tag_a + stride_a;
      tag_b <= tag_b + stride_b;
      iter  <= iter_inc;
      a_ok  <= 1'b0;
      b_ok  <= 1'b0;
    end else begin
      if (cap_a) a_ok <= 1'b1;
      if (cap_b) b_ok <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    stripe_lane #(
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (cfg_fire),
      .cap_a(cap_a),
      .cap_b(cap_b),
      .step (step),
      .op   (job_q.op),
      .accum(job_q.accum),
      .d_in (lane_in[i]),
      .res  (lane_res[i])
    );
  end

endmodule

// File: tb/tb_stripe_mac_array.sv
// Directed self-checking bench for stripe_mac_array (8 lanes, 16-bit Q1.14).
module tb_stripe_mac_array;

  localparam int NP = 8;
  localparam int DW = 16;
  localparam int TW = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid, cfg_ready, cfg_accum;
  logic [1:0]        cfg_op;
  logic [TW-1:0]     cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b, cfg_iter_lim;
  logic              in_valid;
  logic [TW-1:0]     in_tag;
  logic [NP*DW-1:0]  in_data, out_data;
  logic              out_valid, out_ready, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stripe_mac_array #(.NUM_PE(NP), .DATA_W(DW), .FRAC_W(14), .ACC_W(32), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op), .cfg_accum(cfg_accum),
    .cfg_tag_a(cfg_tag_a), .cfg_tag_b(cfg_tag_b),
    .cfg_stride_a(cfg_stride_a), .cfg_stride_b(cfg_stride_b), .cfg_iter_lim(cfg_iter_lim),
    .in_valid(in_valid), .in_tag(in_tag), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc;
    @(negedge clk);
  endtask

  function automatic logic [NP*DW-1:0] splat(input logic [DW-1:0] v);
    logic [NP*DW-1:0] r;
    for (int i = 0; i < NP; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic do_cfg(input logic [1:0] op, input logic acc, input logic [TW-1:0] ta,
                        input logic [TW-1:0] tb, input logic [TW-1:0] sa,
                        input logic [TW-1:0] sb, input logic [TW-1:0] lim);
    cfg_op = op; cfg_accum = acc; cfg_tag_a = ta; cfg_tag_b = tb;
    cfg_stride_a = sa; cfg_stride_b = sb; cfg_iter_lim = lim;
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [TW-1:0] tag, input logic [NP*DW-1:0] d);
    in_valid = 1'b1; in_tag = tag; in_data = d;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else cyc();
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) cyc();
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_accum_mul;
    bit got;
    do_cfg(2'b10, 1'b1, 12'h010, 12'h100, 12'd1, 12'd1, 12'd3);
    send(12'h100, splat(16'h2000));
    send(12'h010, splat(16'h4000));
    cyc();
    send(12'h010, splat(16'h7FFF));   // stale tag, must be ignored
    send(12'h011, splat(16'h4000));
    send(12'h101, splat(16'h2000));
    cyc();
    send(12'h102, splat(16'h2000));
    send(12'h102, splat(16'h7FFF));   // duplicate, first capture wins
    send(12'h012, splat(16'h4000));
    wait_valid(got);
    n_tests++; if (!got) begin n_fail++; $display("FAIL mul_timeout: got no out_valid expected out_valid"); end
    n_tests++; if (out_data !== splat(16'h6000)) begin n_fail++; $display("FAIL mul_data: got %h expected %h", out_data, splat(16'h6000)); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy_done: got %b expected 1", busy); end
    release_out();
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL mul_idle_after: got %b expected 1", cfg_ready); end
  endtask

  task automatic test_shared_wrap;
    bit got;
    do_cfg(2'b00, 1'b1, 12'hFFF, 12'hFFF, 12'd2, 12'd2, 12'd2);
    send(12'hFFF, splat(16'h1000));
    cyc();
    send(12'h001, splat(16'h0800));
    wait_valid(got);
    n_tests++; if (!got) begin n_fail++; $display("FAIL wrap_timeout: got no out_valid expected out_valid"); end
    n_tests++; if (out_data !== splat(16'h3000)) begin n_fail++; $display("FAIL wrap_data: got %h expected %h", out_data, splat(16'h3000)); end
    release_out();
  endtask

  task automatic test_overflow;
    bit got;
    logic [DW-1:0] e;
`ifdef STRIPE_SAT_EN
    e = 16'h7FFF;
`else
    e = 16'hE000;
`endif
    do_cfg(2'b00, 1'b0, 12'h001, 12'h002, 12'd0, 12'd0, 12'd1);
    send(12'h001, splat(16'h7000));
    send(12'h002, splat(16'h7000));
    wait_valid(got);
    n_tests++; if (!got) begin n_fail++; $display("FAIL ovf_timeout: got no out_valid expected out_valid"); end
    n_tests++; if (out_data !== splat(e)) begin n_fail++; $display("FAIL ovf_data: got %h expected %h", out_data, splat(e)); end
    release_out();
  endtask

  task automatic test_backpressure;
    bit got;
    logic [NP*DW-1:0] a, e;
    for (int i = 0; i < NP; i++) begin
      a[i*DW +: DW] = DW'(i * 16'h0100);
      e[i*DW +: DW] = DW'(i * 16'h0100 - 16'h0080);
    end
    do_cfg(2'b01, 1'b0, 12'h040, 12'h041, 12'd0, 12'd0, 12'd1);
    send(12'h040, a);
    send(12'h041, splat(16'h0080));
    wait_valid(got);
    n_tests++; if (!got) begin n_fail++; $display("FAIL bp_timeout: got no out_valid expected out_valid"); end
    for (int k = 0; k < 5; k++) begin
      cfg_valid = 1'b1; cfg_iter_lim = 12'd0; cfg_op = 2'b00;
      cyc();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b expected 1", out_valid); end
      n_tests++; if (out_data !== e) begin n_fail++; $display("FAIL bp_data_held: got %h expected %h", out_data, e); end
      n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cfg_ready: got %b expected 0", cfg_ready); end
    end
    cfg_valid = 1'b0;
    release_out();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", cfg_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_zero_len_drop;
    bit got;
    do_cfg(2'b00, 1'b1, 12'h000, 12'h000, 12'd0, 12'd0, 12'd0);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b expected 1", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL zero_data: got %h expected 0", out_data); end
    release_out();
    do_cfg(2'b00, 1'b1, 12'h020, 12'h020, 12'd1, 12'd1, 12'd2);
    send(12'h020, splat(16'h0100));
    send(12'h021, splat(16'h0200));   // arrives during COMPUTE, dropped
    repeat (3) cyc();
    n_tests++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_stall: got busy=%b valid=%b expected busy=1 valid=0", busy, out_valid); end
    send(12'h021, splat(16'h0200));
    wait_valid(got);
    n_tests++; if (!got) begin n_fail++; $display("FAIL drop_timeout: got no out_valid expected out_valid"); end
    n_tests++; if (out_data !== splat(16'h0600)) begin n_fail++; $display("FAIL drop_data: got %h expected %h", out_data, splat(16'h0600)); end
    release_out();
  endtask

  task automatic test_reset_mid;
    do_cfg(2'b00, 1'b0, 12'h030, 12'h031, 12'd0, 12'd0, 12'd1);
    send(12'h030, splat(16'h1111));
    rst = 1'b0;
    cyc(); cyc();
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_cfg_ready: got %b expected 1", cfg_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL rmid_data: got %h expected 0", out_data); end
    rst = 1'b1;
    cyc();
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_idle: got %b expected 1", cfg_ready); end
    // Minimum-latency job: shared tag on the first COLLECT cycle, iter_lim 1.
    do_cfg(2'b00, 1'b0, 12'h005, 12'h005, 12'd0, 12'd0, 12'd1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_c1: got %b expected 0", out_valid); end
    send(12'h005, splat(16'h0100));
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_c2: got %b expected 0", out_valid); end
    cyc();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_c3: got %b expected 1", out_valid); end
    n_tests++; if (out_data !== splat(16'h0200)) begin n_fail++; $display("FAIL lat_data: got %h expected %h", out_data, splat(16'h0200)); end
    release_out();
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_op = '0; cfg_accum = 1'b0;
    cfg_tag_a = '0; cfg_tag_b = '0; cfg_stride_a = '0; cfg_stride_b = '0; cfg_iter_lim = '0;
    in_valid = 1'b0; in_tag = '0; in_data = '0; out_ready = 1'b0;
    cyc();
    test_reset();
    test_accum_mul();
    test_shared_wrap();
    test_overflow();
    test_backpressure();
    test_zero_len_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
